// File: rtl/gelato_types_pkg.sv
// rtl/gelato_types_pkg.sv - shared warp/register types for the gelato scoreboard.
package gelato_types;
  localparam int WARP_NUM = 8;
  localparam int REG_W    = 5;
  localparam int WARP_W   = $clog2(WARP_NUM);

  typedef logic [WARP_W-1:0] warp_num_t;
  typedef logic [REG_W-1:0]  reg_num_t;

  typedef struct packed {
    warp_num_t warp;
    reg_num_t  regn;
  } sb_release_t;
endpackage

// File: rtl/gelato_rr_arbiter.sv
// rtl/gelato_rr_arbiter.sv - round-robin one-hot grant; pointer moves past the winner on advance.
module gelato_rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] grant_idx;
  int            idx;

  // Scan from the farthest offset down so the request nearest the pointer wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
      end
    end
    ptr_d = advance ? PW'((int'(grant_idx) + 1) % N) : ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/gelato_scoreboard_release.sv
// rtl/gelato_scoreboard_release.sv - queues writeback completions and releases one dirty register per cycle.
module gelato_scoreboard_release
  import gelato_types::*;
#(
  parameter int NUM_WB     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WB-1:0]          wb_valid,
  output logic [NUM_WB-1:0]          wb_ready,
  input  logic [NUM_WB*WARP_W-1:0]   wb_warp_num,
  input  logic [NUM_WB*REG_W-1:0]    wb_reg,
  output logic                       rel_valid,
  input  logic                       rel_ready,
  output warp_num_t                  rel_warp_num,
  output reg_num_t                   rel_reg,
  output logic [WARP_NUM-1:0]        warp_drained
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [NUM_WB-1:0] grant;
  logic              full, empty, hs, push, pop;
  sb_release_t       sel, head;
  sb_release_t       mem_q [FIFO_DEPTH];
  sb_release_t       mem_d [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q [WARP_NUM];
  logic [CW-1:0]     cnt_d [WARP_NUM];

  gelato_rr_arbiter #(.N(NUM_WB)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wb_valid),
    .advance (hs),
    .grant   (grant)
  );

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  // Full blocks acceptance even when a pop is happening in the same cycle.
  assign wb_ready = grant & {NUM_WB{!full && !rst}};
  assign hs       = |wb_ready;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign push     = hs && (sel.regn != '0);
  assign pop      = !empty && rel_ready;

  assign rel_valid    = !empty;
  assign rel_warp_num = empty ? '0 : head.warp;
  assign rel_reg      = empty ? '0 : head.regn;

  always_comb begin
    sel = '0;
    for (int p = 0; p < NUM_WB; p++) begin
      if (grant[p]) begin
        sel.warp = wb_warp_num[p*WARP_W +: WARP_W];
        sel.regn = wb_reg[p*REG_W +: REG_W];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
    if (push) mem_d[wr_ptr_q[AW-1:0]] = sel;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  // A push and a pop for the same warp cancel out.
  always_comb begin
    for (int w = 0; w < WARP_NUM; w++) begin
      cnt_d[w] = cnt_q[w];
      if ((push && sel.warp == warp_num_t'(w)) && !(pop && head.warp == warp_num_t'(w)))
        cnt_d[w] = cnt_q[w] + CW'(1);
      else if ((pop && head.warp == warp_num_t'(w)) && !(push && sel.warp == warp_num_t'(w)))
        cnt_d[w] = cnt_q[w] - CW'(1);
      warp_drained[w] = (cnt_q[w] == '0);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int w = 0; w < WARP_NUM; w++) cnt_q[w] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int w = 0; w < WARP_NUM; w++) cnt_q[w] <= cnt_d[w];
    end
  end
endmodule

// File: tb/tb_gelato_scoreboard_release.sv
// tb/tb_gelato_scoreboard_release.sv - directed stimulus with a release scoreboard for gelato_scoreboard_release.
module tb_gelato_scoreboard_release;
  import gelato_types::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [1:0]             wb_valid, wb_ready;
  logic [2*WARP_W-1:0]    wb_warp_num;
  logic [2*REG_W-1:0]     wb_reg;
  logic                   rel_valid, rel_ready;
  warp_num_t              rel_warp_num;
  reg_num_t               rel_reg;
  logic [WARP_NUM-1:0]    warp_drained;

  sb_release_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  gelato_scoreboard_release #(.NUM_WB(2), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_warp_num  (wb_warp_num),
    .wb_reg       (wb_reg),
    .rel_valid    (rel_valid),
    .rel_ready    (rel_ready),
    .rel_warp_num (rel_warp_num),
    .rel_reg      (rel_reg),
    .warp_drained (warp_drained)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input int p, input logic v, input int w, input int r);
    wb_valid[p]                    = v;
    wb_warp_num[p*WARP_W +: WARP_W] = WARP_W'(w);
    wb_reg[p*REG_W +: REG_W]       = REG_W'(r);
  endtask

  task automatic expect_rel(input int w, input int r);
    sb_release_t e;
    e.warp = WARP_W'(w);
    e.regn = REG_W'(r);
    exp_q.push_back(e);
  endtask

  // Release monitor: every consumed release must match the oldest expectation.
  always @(negedge clk) begin
    sb_release_t e;
    if (!rst && rel_valid && rel_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_release: got %0h/%0h expected none", rel_warp_num, rel_reg);
      end else begin
        e = exp_q.pop_front();
        check("rel_warp_num", 32'(rel_warp_num), 32'(e.warp));
        check("rel_reg", 32'(rel_reg), 32'(e.regn));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rel_ready = 1'b0;
    wb_valid = '0; wb_warp_num = '0; wb_reg = '0;
    step(); step();
    sample();
    check("reset_rel_valid", 32'(rel_valid), 32'h0);
    check("reset_rel_warp", 32'(rel_warp_num), 32'h0);
    check("reset_rel_reg", 32'(rel_reg), 32'h0);
    check("reset_drained", 32'(warp_drained), 32'hFF);
    check("reset_wb_ready", 32'(wb_ready), 32'h0);
    step(); rst = 1'b0;

    // Single completion: port0 warp 3 reg 7
    step(); rel_ready = 1'b1; drive(0, 1'b1, 3, 7); expect_rel(3, 7);
    sample();
    check("single_wb_ready", 32'(wb_ready), 32'h1);
    check("single_drained_pre", 32'(warp_drained), 32'hFF);
    step(); drive(0, 1'b0, 0, 0);
    sample();
    check("single_rel_valid", 32'(rel_valid), 32'h1);
    check("single_drained_busy", 32'(warp_drained), 32'hF7);
    step();
    sample();
    check("single_rel_valid_after", 32'(rel_valid), 32'h0);
    check("single_drained_after", 32'(warp_drained), 32'hFF);

    // Register zero on port1: handshaken, never released
    step(); drive(1, 1'b1, 4, 0);
    sample();
    check("reg0_wb_ready", 32'(wb_ready), 32'h2);
    step(); drive(1, 1'b0, 0, 0);
    sample();
    check("reg0_rel_valid", 32'(rel_valid), 32'h0);
    check("reg0_drained", 32'(warp_drained), 32'hFF);

    // Contention: both ports valid, grants alternate 0,1,0,1
    step(); drive(0, 1'b1, 1, 10); drive(1, 1'b1, 2, 11);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) expect_rel(1, 10); else expect_rel(2, 11);
      sample();
      check("contention_grant", 32'(wb_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      step();
    end
    drive(0, 1'b0, 0, 0); drive(1, 1'b0, 0, 0);
    sample();
    check("contention_tail_valid", 32'(rel_valid), 32'h1);
    step();
    sample();
    check("contention_drained", 32'(rel_valid), 32'h0);

    // Backpressure: 5 offered, 4 fit
    step(); rel_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, 6, i + 1);
      if (i < 4) expect_rel(6, i + 1);
      sample();
      check("bp_wb_ready", 32'(wb_ready), (i < 4) ? 32'h1 : 32'h0);
      if (i > 0) check("bp_head_stable", 32'(rel_reg), 32'h1);
      step();
    end
    sample();
    check("bp_full_ready", 32'(wb_ready), 32'h0);
    check("bp_head_warp", 32'(rel_warp_num), 32'h6);
    check("bp_head_reg", 32'(rel_reg), 32'h1);
    check("bp_drained", 32'(warp_drained), 32'hBF);
    step(); rel_ready = 1'b1; expect_rel(6, 5);
    sample();
    check("bp_pop_on_full_ready", 32'(wb_ready), 32'h0);
    step();
    sample();
    check("bp_fifth_ready", 32'(wb_ready), 32'h1);
    step(); drive(0, 1'b0, 0, 0);
    step(); step(); step();
    sample();
    check("bp_empty", 32'(rel_valid), 32'h0);
    check("bp_drained_after", 32'(warp_drained), 32'hFF);

    // Simultaneous push/pop for warp 5 at depth 2
    step(); rel_ready = 1'b0; drive(1, 1'b1, 5, 8); expect_rel(5, 8);
    step(); drive(1, 1'b1, 5, 9); expect_rel(5, 9);
    step(); rel_ready = 1'b1; drive(1, 1'b1, 5, 12); expect_rel(5, 12);
    sample();
    check("pp_wb_ready", 32'(wb_ready), 32'h2);
    check("pp_drained", 32'(warp_drained), 32'hDF);
    step(); drive(1, 1'b0, 0, 0);
    sample();
    check("pp_valid_d2", 32'(rel_valid), 32'h1);
    check("pp_drained_d2", 32'(warp_drained), 32'hDF);
    step();
    sample();
    check("pp_valid_d1", 32'(rel_valid), 32'h1);
    check("pp_drained_d1", 32'(warp_drained), 32'hDF);
    step();
    sample();
    check("pp_valid_d0", 32'(rel_valid), 32'h0);
    check("pp_drained_d0", 32'(warp_drained), 32'hFF);

    // Mid-traffic reset with 3 queued
    step(); rel_ready = 1'b0; drive(0, 1'b1, 2, 3); expect_rel(2, 3);
    step(); drive(0, 1'b1, 2, 4); expect_rel(2, 4);
    step(); drive(0, 1'b1, 2, 5); expect_rel(2, 5);
    step(); drive(0, 1'b0, 0, 0);
    sample();
    check("mrst_valid_pre", 32'(rel_valid), 32'h1);
    check("mrst_drained_pre", 32'(warp_drained), 32'hFB);
    step(); exp_q.delete(); rst = 1'b1; drive(0, 1'b1, 2, 6);
    sample();
    check("mrst_rel_valid", 32'(rel_valid), 32'h0);
    check("mrst_drained", 32'(warp_drained), 32'hFF);
    check("mrst_rel_reg", 32'(rel_reg), 32'h0);
    check("mrst_wb_ready", 32'(wb_ready), 32'h0);
    step(); drive(0, 1'b0, 0, 0); rst = 1'b0; rel_ready = 1'b1;
    step();
    sample();
    check("mrst_discarded", 32'(rel_valid), 32'h0);
    step();
    sample();
    check("mrst_discarded2", 32'(rel_valid), 32'h0);

    check("exp_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
